// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID buffer.
//   RstEnable   - asserted level of the synchronous reset
//   ZeroWord    - bubble value shown on the decode side when empty
//   InstAddrBus / InstBus widths - defaults for ADDR_W / INST_W
package if_id_queue_pkg;

    localparam logic        RstEnable      = 1'b1;
    localparam int          INST_ADDR_BUS_W = 32;
    localparam int          INST_BUS_W      = 32;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH x {pc, inst} register array: one synchronous write port and one
// asynchronous read port. Contents are never cleared; the owner masks the
// read data when nothing valid is stored.
//   clk              clock
//   we/waddr         write enable and index
//   wpc/winst        write data
//   raddr            read index
//   rpc/rinst        read data (combinational)
module if_id_fifo_mem #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wpc,
    input  logic [INST_W-1:0] winst,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rpc,
    output logic [INST_W-1:0] rinst
);

    logic [ADDR_W+INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= {wpc, winst};
    end

    assign {rpc, rinst} = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID pipeline buffer: DEPTH-entry FIFO between fetch and decode with
// valid/ready on both sides. Absorbs decode stalls and drops everything
// buffered (and anything arriving) on flush.
//   clk, rst                     clock, synchronous active-high reset
//   flush                        discard buffered and incoming entries
//   if_valid/if_ready/if_pc/if_inst   fetch side
//   id_valid/id_ready/id_pc/id_inst   decode side (zero when empty)
//   count                        current occupancy
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS_W,
    parameter int INST_W = INST_BUS_W,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop;
    logic [ADDR_W-1:0] rd_pc;
    logic [INST_W-1:0] rd_inst;

    // Both handshakes come from registered state only, so there is no
    // combinational path from id_ready to if_ready.
    assign if_ready = (count != CNT_W'(DEPTH));
    assign id_valid = (count != '0);

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    if_id_fifo_mem #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wpc   (if_pc),
        .winst (if_inst),
        .raddr (rd_ptr),
        .rpc   (rd_pc),
        .rinst (rd_inst)
    );

    // Stale storage is hidden behind a zero bubble when empty.
    assign id_pc   = id_valid ? rd_pc   : '0;
    assign id_inst = id_valid ? rd_inst : '0;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID pipeline buffer that replaces the single-register IF/ID latch with a DEPTH-entry FIFO and valid/ready handshakes on both sides. It sits between the fetch stage (PC register plus instruction ROM) and the decode stage. It absorbs decode stalls without dropping fetched instructions, and discards all buffered instructions on a branch/jump flush.

## Interface
- ADDR_W, 32, instruction address width
- INST_W, 32, instruction word width
- DEPTH, 2, number of buffer entries; power of two, ≥ 2
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered and incoming instructions (from EX on redirect)
- if_valid  in  1  fetch presents a valid pc/inst pair
- if_ready  out  1  buffer can accept an entry this cycle
- if_pc  in  ADDR_W  fetch PC
- if_inst  in  INST_W  fetched instruction
- id_valid  out  1  head entry valid for decode
- id_ready  in  1  decode consumes the head entry this cycle
- id_pc  out  ADDR_W  PC of the head entry
- id_inst  out  INST_W  instruction of the head entry
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH × {pc, inst} register array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, and an occupancy counter.
- Push = if_valid & if_ready & ~flush. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- Pop = id_valid & id_ready & ~flush. rd_ptr increments modulo DEPTH.
- if_ready = (count != DEPTH). It depends only on registered state, with no combinational path from id_ready.
- id_valid = (count != 0).
- id_pc / id_inst = entry[rd_ptr] when id_valid, else all-zero. Zero inst is the defined empty/bubble value.
- count next value:
  - push & ~pop: +1
  - pop & ~push: −1
  - both, or neither: unchanged
- Push and pop in the same cycle are legal whenever 0 < count < DEPTH.
- Priority: rst > flush > push/pop.
- Flush: next cycle count = 0, wr_ptr = rd_ptr = 0, id_valid = 0. Any same-cycle push is dropped and any same-cycle pop is ignored.
- Storage contents are not cleared by rst or flush; they are unobservable because outputs are masked when empty.
- Protocol rule: fetch holds if_pc/if_inst stable while if_valid & ~if_ready. The buffer does not check this.

## Timing
- Reset values (cycle after rst sampled high): id_valid = 0, id_pc = 0, id_inst = 0, if_ready = 1, count = 0, both pointers 0.
- Latency: push in cycle N → id_valid = 1 with that entry from cycle N+1. There is no same-cycle bypass.
- Throughput: 1 entry/cycle sustained when id_ready is held high.
- Full (count = DEPTH): if_ready = 0. A pop in that cycle raises if_ready in the next cycle, not the same one.
- Empty (count = 0): id_valid = 0, and id_ready is ignored.
- Flush asserted for several cycles: the buffer stays empty, and if_ready stays 1 throughout.
- Reset mid-operation: all in-flight entries are lost. Reset values appear the next cycle regardless of flush, push or pop.

## Structure
- Shared defs: RstEnable, ZeroWord, InstAddrBus/InstBus widths. These are the defaults for ADDR_W/INST_W.
- One natural sub-module: if_id_fifo_mem, the DEPTH × (ADDR_W+INST_W) register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic stay in if_id_queue.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- Reset then idle: after rst, expect id_valid=0, id_pc=0, id_inst=0, if_ready=1, count=0.
- Streaming, DEPTH=2, id_ready=1: push pc 0x0,0x4,0x8 on consecutive cycles → id_pc shows 0x0,0x4,0x8 one cycle later each; count stays 1.
- Stall to full: id_ready=0, push 0x10 and 0x14 → count=2, if_ready=0, and a held push of 0x18 is not accepted. Raise id_ready → 0x10, 0x14, 0x18 drain in order; if_ready returns 1 one cycle after the first pop.
- Flush with simultaneous push: count=2, assert flush together with if_valid (pc 0x20) → next cycle count=0, id_valid=0, and 0x20 never appears at the output.
- Wrap-around, DEPTH=4: push/pop 10 entries with random id_ready stalls → output order matches input order and count never exceeds 4.
- Reset mid-stream: count=3, assert rst together with flush and push → next cycle all outputs match the reset values.
